dm_sized: RTL and testbench

//  Parametrised single-port data memory for the MIPS datapath (MEM stage).

---
 rtl/dm_sized_if.sv | 26 ++
 rtl/dm_sized.sv | 214 +++++++++++++++++++++
 tb/tb_dm_sized.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dm_sized_if.sv
// Request/response bundle between the MEM stage and the data memory.
// The master issues accesses; the slave (dm_sized) answers with load data and flags.
interface dm_sized_if #(
  parameter int ADDR_W = 12
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic              uext;
  logic [31:0]       wd;
  logic              ready;
  logic              rvalid;
  logic [31:0]       rd;
  logic              misalign;

  modport master (
    output req, we, addr, size, uext, wd,
    input  ready, rvalid, rd, misalign
  );

  modport slave (
    input  req, we, addr, size, uext, wd,
    output ready, rvalid, rd, misalign
  );
endinterface

// File: rtl/dm_sized.sv
// Single-port big-endian data memory for the MEM stage.
// Byte/half/word stores with lane enables, sign/zero-extending loads with a
// one-cycle registered response, misalignment flagging, and a post-reset
// sequencer that zeroes every word before the first access is accepted.
module dm_sized #(
  parameter int ADDR_W     = 12,
  parameter int INIT_CLEAR = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  dm_sized_if.slave  bus
);
  localparam int WORD_W = ADDR_W - 2;
  localparam int DEPTH  = 1 << WORD_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(DEPTH - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [0:0] {
    S_CLEAR,
    S_READY
  } state_t;

  state_t state_reg, state_next;
  logic [WORD_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic              ready_reg;

  // Storage; no reset so it maps onto block RAM with byte-lane enables.
  logic [31:0] mem [DEPTH];
  logic [31:0] mem_q;

  // Response pipeline (one slot, filled at the accept edge).
  logic        resp_load_reg;
  logic        resp_mis_reg;
  logic [1:0]  resp_size_reg;
  logic [1:0]  resp_off_reg;
  logic        resp_uext_reg;
  logic [31:0] rd_hold_reg;
  logic [31:0] rd_resp;

  // Decoded request.
  logic [WORD_W-1:0] word_idx;
  logic [1:0]        byte_off;
  logic              accept;
  logic              misaligned;
  logic              rd_en;

  // Memory write port, shared by the clear sequencer and stores.
  logic              wr_en;
  logic [WORD_W-1:0] wr_idx;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;

  // Lane enables for a store; lane 3 is bits [31:24] (byte offset 0, big-endian).
  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (sz)
      SZ_BYTE: begin
        case (off)
          2'd0:    be = 4'b1000;
          2'd1:    be = 4'b0100;
          2'd2:    be = 4'b0010;
          default: be = 4'b0001;
        endcase
      end
      SZ_HALF: be = off[1] ? 4'b0011 : 4'b1100;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so the enables alone pick the target.
  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Select the addressed lane(s) from a word and extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] off, input logic ue);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      SZ_BYTE: r = ue ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = ue ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign word_idx = bus.addr[ADDR_W-1:2];
  assign byte_off = bus.addr[1:0];
  assign accept   = bus.req && ready_reg;
  assign rd_en    = accept && !bus.we && !misaligned;

  // Alignment check; size 11 is always treated as a fault.
  always_comb begin
    misaligned = 1'b0;
    case (bus.size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = byte_off[0];
      SZ_WORD: misaligned = (byte_off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // State and clear-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= (INIT_CLEAR != 0) ? S_CLEAR : S_READY;
      clr_cnt_reg <= '0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
      ready_reg   <= (state_next == S_READY);
    end
  end

  // Next-state logic and write-port steering.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    wr_en        = 1'b0;
    wr_idx       = word_idx;
    wr_be        = 4'b0000;
    wr_data      = store_data(bus.size, bus.wd);
    case (state_reg)
      S_CLEAR: begin
        wr_en        = 1'b1;
        wr_idx       = clr_cnt_reg;
        wr_be        = 4'b1111;
        wr_data      = 32'h0000_0000;
        clr_cnt_next = clr_cnt_reg + WORD_W'(1);
        if (clr_cnt_reg == LAST_WORD) begin
          state_next   = S_READY;
          clr_cnt_next = '0;
        end
      end
      S_READY: begin
        if (accept && bus.we && !misaligned) begin
          wr_en = 1'b1;
          wr_be = store_be(bus.size, byte_off);
        end
      end
      default: state_next = S_READY;
    endcase
  end

  // Array write with per-lane enables and registered read for loads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
    if (rd_en) mem_q <= mem[word_idx];
  end

  // Response slot: remember what was accepted so the next cycle can format it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_load_reg <= 1'b0;
      resp_mis_reg  <= 1'b0;
      resp_size_reg <= 2'b00;
      resp_off_reg  <= 2'b00;
      resp_uext_reg <= 1'b0;
    end else begin
      resp_load_reg <= accept && !bus.we;
      resp_mis_reg  <= accept && misaligned;
      if (accept && !bus.we) begin
        resp_size_reg <= bus.size;
        resp_off_reg  <= byte_off;
        resp_uext_reg <= bus.uext;
      end
    end
  end

  // A faulting load answers with zero instead of array data.
  assign rd_resp = resp_mis_reg ? 32'h0000_0000
                                : load_extract(mem_q, resp_size_reg, resp_off_reg, resp_uext_reg);

  // Keep the last load result visible on rd between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_hold_reg <= 32'h0000_0000;
    end else if (resp_load_reg) begin
      rd_hold_reg <= rd_resp;
    end
  end

  assign bus.ready    = ready_reg;
  assign bus.rvalid   = resp_load_reg;
  assign bus.misalign = resp_mis_reg;
  assign bus.rd       = resp_load_reg ? rd_resp : rd_hold_reg;

endmodule

// File: tb/tb_dm_sized.sv
// Directed bench for dm_sized with ADDR_W=6 (16 words), INIT_CLEAR=1.
module tb_dm_sized;
  localparam int AW = 6;
  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] SX = 2'b11;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;

  dm_sized_if #(.ADDR_W(AW)) bus ();

  dm_sized #(.ADDR_W(AW), .INIT_CLEAR(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // Present one request for a single clock edge, then sample 1ns after it.
  task automatic access(input logic w, input logic [AW-1:0] a, input logic [1:0] sz,
                        input logic ue, input logic [31:0] d);
    bus.req  = 1'b1;
    bus.we   = w;
    bus.addr = a;
    bus.size = sz;
    bus.uext = ue;
    bus.wd   = d;
    @(posedge clk);
    #1;
    bus.req  = 1'b0;
    bus.we   = 1'b0;
  endtask

  task automatic load(input string tag, input logic [AW-1:0] a, input logic [1:0] sz,
                      input logic ue, input logic [31:0] exp);
    access(1'b0, a, sz, ue, 32'h0);
    check({tag, "_rvalid"}, {31'b0, bus.rvalid}, 32'd1);
    check({tag, "_mis"}, {31'b0, bus.misalign}, 32'd0);
    check({tag, "_rd"}, bus.rd, exp);
  endtask

  task automatic store(input string tag, input logic [AW-1:0] a, input logic [1:0] sz,
                       input logic [31:0] d);
    access(1'b1, a, sz, 1'b0, d);
    check({tag, "_rvalid"}, {31'b0, bus.rvalid}, 32'd0);
    check({tag, "_mis"}, {31'b0, bus.misalign}, 32'd0);
  endtask

  // Release reset at a falling edge and expect exactly 16 not-ready cycles.
  task automatic release_and_clear(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_busy%0d", tag, i), {31'b0, bus.ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    check({tag, "_ready"}, {31'b0, bus.ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    passes   = 0;
    rst_n    = 1'b0;
    bus.req  = 1'b0;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.size = SW;
    bus.uext = 1'b0;
    bus.wd   = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, bus.ready}, 32'd0);
    check("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
    check("rst_mis", {31'b0, bus.misalign}, 32'd0);
    check("rst_rd", bus.rd, 32'h0);

    // 1. Clear sequence, then every word reads zero
    release_and_clear("clr");
    for (int i = 0; i < 16; i++) load($sformatf("clr_w%0d", i), AW'(i * 4), SW, 1'b0, 32'h0);

    // 2. Word store, unsigned byte loads from big-endian lanes
    store("sw10", 6'h10, SW, 32'h1122_3344);
    load("lbu10", 6'h10, SB, 1'b1, 32'h0000_0011);
    load("lbu11", 6'h11, SB, 1'b1, 32'h0000_0022);
    load("lbu13", 6'h13, SB, 1'b1, 32'h0000_0044);
    load("lw10", 6'h10, SW, 1'b0, 32'h1122_3344);

    // 3. Byte store into lane 1 of word 0x20, signed and unsigned readback
    store("sb21", 6'h21, SB, 32'hFFFF_FF80);
    load("lw20", 6'h20, SW, 1'b0, 32'h0080_0000);
    load("lb21", 6'h21, SB, 1'b0, 32'hFFFF_FF80);
    load("lbu21", 6'h21, SB, 1'b1, 32'h0000_0080);

    // 4. Half store to low half, read-after-write on the very next cycle
    store("sh32", 6'h32, SH, 32'h1234_BEEF);
    load("lh32", 6'h32, SH, 1'b0, 32'hFFFF_BEEF);
    load("lhu32", 6'h32, SH, 1'b1, 32'h0000_BEEF);
    load("lw30", 6'h30, SW, 1'b0, 32'h0000_BEEF);
    load("lhu30", 6'h30, SH, 1'b1, 32'h0000_0000);

    // Idle cycle: no pulses, rd holds the last result
    @(posedge clk);
    #1;
    check("idle_rvalid", {31'b0, bus.rvalid}, 32'd0);
    check("idle_mis", {31'b0, bus.misalign}, 32'd0);
    check("idle_rd", bus.rd, 32'h0000_0000);

    // 5. Misaligned load: misalign + rvalid with rd=0
    load("lw30b", 6'h30, SW, 1'b0, 32'h0000_BEEF);
    access(1'b0, 6'h05, SW, 1'b0, 32'h0);
    check("lw05_rvalid", {31'b0, bus.rvalid}, 32'd1);
    check("lw05_mis", {31'b0, bus.misalign}, 32'd1);
    check("lw05_rd", bus.rd, 32'h0);

    // Misaligned store to word 0x40 (wraps to word 0 with a 6-bit address)
    store("sw40", 6'h00, SW, 32'hCAFE_F00D);
    load("lbu40_hold", 6'h00, SB, 1'b1, 32'h0000_00CA);
    access(1'b1, 6'h01, SH, 1'b0, 32'h0000_1234);
    check("sh41_mis", {31'b0, bus.misalign}, 32'd1);
    check("sh41_rvalid", {31'b0, bus.rvalid}, 32'd0);
    check("sh41_rdhold", bus.rd, 32'h0000_00CA);
    load("lw40", 6'h00, SW, 1'b0, 32'hCAFE_F00D);

    // Illegal size is always a fault
    access(1'b0, 6'h00, SX, 1'b0, 32'h0);
    check("lx_rvalid", {31'b0, bus.rvalid}, 32'd1);
    check("lx_mis", {31'b0, bus.misalign}, 32'd1);
    check("lx_rd", bus.rd, 32'h0);

    // 6. Back-to-back store/load stream, then reset mid-stream
    for (int i = 0; i < 4; i++) begin
      store($sformatf("strm_sw%0d", i), AW'((8 + i) * 4), SW, 32'hA500_0000 + 32'(i));
      load($sformatf("strm_lw%0d", i), AW'((8 + i) * 4), SW, 1'b0, 32'hA500_0000 + 32'(i));
    end
    access(1'b0, 6'h24, SW, 1'b0, 32'h0);
    check("strm_pend_rvalid", {31'b0, bus.rvalid}, 32'd1);
    bus.req  = 1'b1;
    bus.we   = 1'b1;
    bus.addr = 6'h28;
    bus.wd   = 32'hDEAD_BEEF;
    rst_n    = 1'b0;
    #1;
    check("mrst_rvalid", {31'b0, bus.rvalid}, 32'd0);
    check("mrst_mis", {31'b0, bus.misalign}, 32'd0);
    check("mrst_ready", {31'b0, bus.ready}, 32'd0);
    bus.req = 1'b0;
    bus.we  = 1'b0;
    repeat (2) @(posedge clk);
    release_and_clear("reclr");
    load("reclr_w8", 6'h20, SW, 1'b0, 32'h0);
    load("reclr_w9", 6'h24, SW, 1'b0, 32'h0);
    load("reclr_w10", 6'h28, SW, 1'b0, 32'h0);
    load("reclr_w4", 6'h10, SW, 1'b0, 32'h0);
    load("reclr_w0", 6'h00, SW, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
